product_accumulator: RTL and testbench

//   Downstream consumer of the N-bit unsigned multiplier. It sums TERMS consecutive

---
 rtl/product_accumulator.sv | 129 ++++++++++++
 tb/tb_product_accumulator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Accumulate stage of a dot-product datapath: sums TERMS unsigned products behind a
// valid/ready input and holds each sum on a valid/ready result port.
// Build option: define SATURATE_EN to clamp on overflow; otherwise the sum wraps.
module product_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 2*N+8,
  parameter int TERMS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N:0]     product,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             overflow,
  output logic [7:0]       term_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  localparam logic [7:0]       TERMS_C = 8'(TERMS);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             accept;
  logic [ACC_W:0]   add_full;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  // in_ready is gated by rst_n so the block refuses products while reset is held,
  // yet is ready on the very first cycle back in IDLE.
  assign in_ready = rst_n && (state_q != S_DONE);
  assign accept   = in_valid && in_ready;

  // The adder is one bit wider than the accumulator; its top bit is the carry
  // that flags overflow.
  assign acc_base = (state_q == S_IDLE) ? '0 : acc_q;
  assign add_full = {1'b0, acc_base} + (ACC_W+1)'(product);
  assign ovf_next = ovf_q | add_full[ACC_W];

`ifdef SATURATE_EN
  assign acc_next = ovf_next ? ACC_MAX : add_full[ACC_W-1:0];
`else
  assign acc_next = add_full[ACC_W-1:0];
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (clear) begin
          state_d = S_IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = 8'd0;
        end else if (accept) begin
          acc_d = acc_next;
          ovf_d = ovf_next;
          cnt_d = (state_q == S_IDLE) ? 8'd1 : cnt_q + 8'd1;
          if (cnt_d == TERMS_C) begin
            state_d = S_DONE;
            sum_d   = acc_next;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_DONE: begin
        // clear is deliberately ignored here so a finished sum cannot be lost.
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed table, corner sequences and
// random traffic compared against an arithmetic model of running totals.
module tb_product_accumulator;

  localparam int N     = 8;
  localparam int ACC_W = 17;
  localparam int TERMS = 4;
  localparam int PW    = 2*N+1;
  localparam longint MAX = (64'd1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    product;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic             overflow;
  logic [7:0]       term_cnt;

  product_accumulator #(.N(N), .ACC_W(ACC_W), .TERMS(TERMS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow),
    .term_cnt  (term_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the list of accepted products reduced to a running total.
  longint           m_total;
  int               m_cnt;
  bit               m_pending;
  logic [ACC_W-1:0] m_sum;

  typedef struct {
    logic             iv;
    logic [PW-1:0]    p;
    logic             ordy;
    logic             e_ov;
    logic [ACC_W-1:0] e_sum;
    logic             e_ir;
    logic [7:0]       e_cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] fold(input longint t);
`ifdef SATURATE_EN
    return (t > MAX) ? ACC_W'(MAX) : ACC_W'(t);
`else
    return ACC_W'(t % (MAX + 1));
`endif
  endfunction

  task automatic model_reset();
    m_total   = 0;
    m_cnt     = 0;
    m_pending = 1'b0;
    m_sum     = '0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".in_ready"},  64'(in_ready),  64'(rst_n && !m_pending));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_pending));
    check({tag, ".sum"},       64'(sum),       64'(m_sum));
    check({tag, ".overflow"},  64'(overflow),  64'(m_total > MAX));
    check({tag, ".term_cnt"},  64'(term_cnt),  64'(m_cnt));
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then compares.
  task automatic cycle(input string tag, input logic iv, input logic [PW-1:0] p,
                       input logic clr, input logic ordy);
    in_valid  = iv;
    product   = p;
    clear     = clr;
    out_ready = ordy;
    @(posedge clk);
    if (m_pending) begin
      if (ordy) begin
        m_pending = 1'b0;
        m_cnt     = 0;
        m_total   = 0;
      end
    end else if (clr) begin
      m_cnt   = 0;
      m_total = 0;
    end else if (iv) begin
      m_total += longint'(p);
      m_cnt++;
      if (m_cnt == TERMS) begin
        m_pending = 1'b1;
        m_sum     = fold(m_total);
      end
    end
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    product   = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready",  64'(in_ready),  64'd0);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.sum",       64'(sum),       64'd0);
    check("reset.overflow",  64'(overflow),  64'd0);
    check("reset.term_cnt",  64'(term_cnt),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release.in_ready", 64'(in_ready), 64'd1);

    // Products 3,5,7,9 back to back, then in_valid toggling 10,20,30,40.
    tbl[0]  = '{1'b1, 17'd3,  1'b1, 1'b0, 17'd0,   1'b1, 8'd1};
    tbl[1]  = '{1'b1, 17'd5,  1'b1, 1'b0, 17'd0,   1'b1, 8'd2};
    tbl[2]  = '{1'b1, 17'd7,  1'b1, 1'b0, 17'd0,   1'b1, 8'd3};
    tbl[3]  = '{1'b1, 17'd9,  1'b1, 1'b1, 17'd24,  1'b0, 8'd4};
    tbl[4]  = '{1'b0, 17'd0,  1'b1, 1'b0, 17'd24,  1'b1, 8'd0};
    tbl[5]  = '{1'b1, 17'd10, 1'b0, 1'b0, 17'd24,  1'b1, 8'd1};
    tbl[6]  = '{1'b0, 17'd77, 1'b0, 1'b0, 17'd24,  1'b1, 8'd1};
    tbl[7]  = '{1'b1, 17'd20, 1'b0, 1'b0, 17'd24,  1'b1, 8'd2};
    tbl[8]  = '{1'b0, 17'd77, 1'b0, 1'b0, 17'd24,  1'b1, 8'd2};
    tbl[9]  = '{1'b1, 17'd30, 1'b0, 1'b0, 17'd24,  1'b1, 8'd3};
    tbl[10] = '{1'b0, 17'd77, 1'b0, 1'b0, 17'd24,  1'b1, 8'd3};
    tbl[11] = '{1'b1, 17'd40, 1'b0, 1'b1, 17'd100, 1'b0, 8'd4};
    tbl[12] = '{1'b0, 17'd0,  1'b1, 1'b0, 17'd100, 1'b1, 8'd0};

    for (int i = 0; i < 13; i++) begin
      cycle($sformatf("vec%0d", i), tbl[i].iv, tbl[i].p, 1'b0, tbl[i].ordy);
      check($sformatf("vec%0d.tbl_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      check($sformatf("vec%0d.tbl_sum", i),       64'(sum),       64'(tbl[i].e_sum));
      check($sformatf("vec%0d.tbl_in_ready", i),  64'(in_ready),  64'(tbl[i].e_ir));
      check($sformatf("vec%0d.tbl_term_cnt", i),  64'(term_cnt),  64'(tbl[i].e_cnt));
    end

    // Result stalled for 5 cycles while products keep being offered.
    for (int i = 1; i <= 4; i++) cycle("stall_fill", 1'b1, PW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle("stall", 1'b1, 17'd99, 1'b0, 1'b0);
      check("stall.in_ready_low", 64'(in_ready), 64'd0);
      check("stall.sum_held",     64'(sum),      64'd10);
      check("stall.no_consume",   64'(term_cnt), 64'd4);
    end
    cycle("stall_take", 1'b1, 17'd99, 1'b0, 1'b1);
    check("stall_take.not_consumed", 64'(term_cnt), 64'd0);
    cycle("stall_next", 1'b1, 17'd99, 1'b0, 1'b1);
    check("stall_next.accepted", 64'(term_cnt), 64'd1);
    cycle("stall_clr", 1'b0, 17'd0, 1'b1, 1'b0);

    // clear after a partial sum of 15 drops it, including a product offered alongside.
    cycle("clr_a", 1'b1, 17'd7, 1'b0, 1'b0);
    cycle("clr_b", 1'b1, 17'd8, 1'b0, 1'b0);
    cycle("clr_hit", 1'b1, 17'd50, 1'b1, 1'b0);
    check("clr_hit.term_cnt", 64'(term_cnt), 64'd0);
    for (int i = 0; i < 4; i++) cycle("clr_ones", 1'b1, 17'd1, 1'b0, 1'b0);
    check("clr_done.sum",      64'(sum),      64'd4);
    check("clr_done.overflow", 64'(overflow), 64'd0);
    cycle("clr_in_done", 1'b0, 17'd0, 1'b1, 1'b0);
    check("clr_in_done.out_valid", 64'(out_valid), 64'd1);
    check("clr_in_done.sum",       64'(sum),       64'd4);
    cycle("clr_take", 1'b0, 17'd0, 1'b0, 1'b1);

    // Overflow: four products of 255*255 into a 17-bit accumulator.
    for (int i = 0; i < 4; i++) cycle("ovf", 1'b1, 17'd65025, 1'b0, 1'b1);
    check("ovf.flag", 64'(overflow), 64'd1);
`ifdef SATURATE_EN
    check("ovf.sum", 64'(sum), 64'd131071);
`else
    check("ovf.sum", 64'(sum), 64'd129028);
`endif
    cycle("ovf_take", 1'b0, 17'd0, 1'b0, 1'b1);
    check("ovf_take.flag_clear", 64'(overflow), 64'd0);

    // Asynchronous reset in the middle of a sum.
    for (int i = 2; i <= 4; i++) cycle("rst_mid", 1'b1, PW'(i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid.in_ready",  64'(in_ready),  64'd0);
    check("rst_mid.out_valid", 64'(out_valid), 64'd0);
    check("rst_mid.sum",       64'(sum),       64'd0);
    check("rst_mid.overflow",  64'(overflow),  64'd0);
    check("rst_mid.term_cnt",  64'(term_cnt),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle("rst_after", 1'b1, 17'd2, 1'b0, 1'b0);
    check("rst_after.sum", 64'(sum), 64'd8);
    cycle("rst_take", 1'b0, 17'd0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic          iv, clr, ordy;
      logic [PW-1:0] p;
      iv   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 19) == 0);
      ordy = $urandom_range(0, 1) == 1;
      p    = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(60000, 65025))
                                         : PW'($urandom_range(0, 65025));
      cycle($sformatf("rand%0d", i), iv, p, clr, ordy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
